uart_stream_tx: RTL and testbench
=================================

UART_STREAM_TX -- requirements
Module: uart_stream_tx

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217: clk_i cycles per UART bit; legal values are 2 or more.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: data bits per frame; legal values are 5 to 8.
REQ-003 The block SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0: 1 selects odd parity, 0 selects even parity; it is ignored when PARITY_EN=0.
REQ-005 The block SHALL have parameter STOP_BITS, default 1: number of stop bits; legal values are 1 or 2.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries; must be a power of 2 and at least 2.
Ports (name, direction, width, meaning):
REQ-007 clk_i, input, 1: the single clock; everything is rising-edge.
REQ-008 rst_ni, input, 1: reset, asynchronous and active-low.
REQ-009 wr_valid_i, input, 1: a write byte is offered.
REQ-010 wr_data_i, input, DATA_BITS: the write byte.
REQ-011 wr_ready_o, output, 1: the FIFO can accept a byte.
REQ-012 fifo_level_o, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-013 busy_o, output, 1: a frame is in progress (FSM is not IDLE).
REQ-014 uart_tx_o, output, 1: serial line; idles high.

Function
REQ-015 Push rule: a byte is pushed on a rising edge where wr_valid_i=1 and wr_ready_o=1.
REQ-016 wr_ready_o SHALL equal !full; it does not depend on a same-cycle pop, so a write while full is not accepted and no FIFO state changes.
REQ-017 The FIFO SHALL be a circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
REQ-018 fifo_level_o SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE with FIFO non-empty: pop the head into the shift register, clear the bit counter and the baud counter, and go to START.
REQ-021 Latency: a byte pushed into an empty FIFO with the FSM in IDLE at edge N SHALL cause uart_tx_o to go low after edge N+1.
REQ-022 Each line bit SHALL last exactly CLKS_PER_BIT cycles; the baud counter counts 0 to CLKS_PER_BIT-1 and then advances the bit.
REQ-023 uart_tx_o per state:
- START: 0.
- DATA: shift-register bit 0, sent LSB first, DATA_BITS bits.
- PARITY: XOR of the data bits, inverted when PARITY_ODD=1.
- STOP: 1 for STOP_BITS bit times.
REQ-024 State transitions:
- DATA goes to PARITY when PARITY_EN=1, otherwise to STOP.
- At the end of the last stop bit, go to START with a pop if the FIFO is non-empty (back-to-back, no idle gap); otherwise go to IDLE.
REQ-025 Frame length SHALL be (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-026 A push in the same cycle as a pop of the last entry SHALL be accepted; the new byte is transmitted next.
REQ-027 uart_tx_o SHALL be driven from a flop, so it is glitch-free.

Reset
REQ-028 When rst_ni=0, outputs SHALL be forced immediately (asynchronously): uart_tx_o=1, busy_o=0, fifo_level_o=0, wr_ready_o=1; FSM goes to IDLE; pointers and counters are cleared.
REQ-029 Reset mid-frame SHALL abandon the frame and discard all FIFO contents; no partial bits follow the release of reset.
REQ-030 After rst_ni rises, the first push SHALL be accepted on the first rising edge of clk_i.

Verification
REQ-031 Defaults except CLKS_PER_BIT=4. Write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each 4 cycles; frame is 40 cycles; busy_o=1 throughout.
REQ-032 PARITY_EN=1, even parity. Write 0x07 -> parity bit 1, frame 44 cycles. With PARITY_ODD=1 -> parity bit 0.
REQ-033 FIFO_DEPTH=4, FSM held busy by a long first frame. Issue 6 consecutive writes -> 5 accepted (1 popped to TX plus 4 stored), then wr_ready_o=0 and fifo_level_o=4. The 6th write is refused.
REQ-034 Write 0x11 and 0x22 back-to-back -> the second start bit immediately follows the first stop bit; there is no high gap longer than STOP_BITS*CLKS_PER_BIT.
REQ-035 Assert rst_ni=0 during the DATA state with 3 bytes queued -> uart_tx_o=1 and fifo_level_o=0 immediately. After release, no frame appears for at least 50 cycles.
REQ-036 STOP_BITS=2, DATA_BITS=5. Write 0x1F -> line 0,1,1,1,1,1,1,1 (start, 5 data, 2 stop); frame is 8*CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/uart_stream_tx.sv
// UART transmitter fed by a small circular FIFO. Bytes queued on the write side are
// framed (start, data LSB first, optional parity, stop) and sent back-to-back on uart_tx_o.
module uart_stream_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wr_valid_i,
    input  logic [DATA_BITS-1:0]          wr_data_i,
    output logic                          wr_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o,
    output logic                          uart_tx_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wrPtr;
    logic [AW-1:0]        r_rdPtr;
    logic [LW-1:0]        r_level;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bitCnt;
    logic                 r_tx;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_baudEnd;

    state_t               w_stateNext;
    logic [DATA_BITS-1:0] w_shiftNext;
    logic                 w_parityNext;
    logic [CW-1:0]        w_baudNext;
    logic [BW-1:0]        w_bitNext;
    logic                 w_txNext;

    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = wr_valid_i && !w_full;
    assign w_head    = r_mem[r_rdPtr];
    assign w_baudEnd = (r_baud == CW'(CLKS_PER_BIT - 1));

    assign wr_ready_o   = !w_full;
    assign fifo_level_o = r_level;
    assign busy_o       = (r_state != S_IDLE);
    assign uart_tx_o    = r_tx;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_baud   <= '0;
            r_bitCnt <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_shift  <= w_shiftNext;
            r_parity <= w_parityNext;
            r_baud   <= w_baudNext;
            r_bitCnt <= w_bitNext;
            r_tx     <= w_txNext;
        end
    end

    // The line level is computed for the state being entered, so the registered
    // output changes on the same edge as the state and never glitches.
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_parityNext = r_parity;
        w_baudNext   = r_baud;
        w_bitNext    = r_bitCnt;
        w_pop        = 1'b0;
        w_txNext     = 1'b1;

        if (r_state != S_IDLE) begin
            w_baudNext = w_baudEnd ? '0 : r_baud + CW'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                end
            end
            S_START: begin
                if (w_baudEnd) begin
                    w_stateNext = S_DATA;
                    w_bitNext   = '0;
                end
            end
            S_DATA: begin
                if (w_baudEnd) begin
                    w_shiftNext = r_shift >> 1;
                    if (r_bitCnt == BW'(DATA_BITS - 1)) begin
                        w_stateNext = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        w_bitNext   = '0;
                    end else begin
                        w_bitNext = r_bitCnt + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_baudEnd) begin
                    w_stateNext = S_STOP;
                    w_bitNext   = '0;
                end
            end
            S_STOP: begin
                if (w_baudEnd) begin
                    if (r_bitCnt == BW'(STOP_BITS - 1)) begin
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_stateNext = S_IDLE;
                            w_bitNext   = '0;
                        end
                    end else begin
                        w_bitNext = r_bitCnt + BW'(1);
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase

        // Loading the next byte restarts the frame with no idle gap.
        if (w_pop) begin
            w_stateNext  = S_START;
            w_shiftNext  = w_head;
            w_parityNext = (^w_head) ^ (PARITY_ODD != 0);
            w_baudNext   = '0;
            w_bitNext    = '0;
        end

        case (w_stateNext)
            S_START:  w_txNext = 1'b0;
            S_DATA:   w_txNext = w_shiftNext[0];
            S_PARITY: w_txNext = w_parityNext;
            default:  w_txNext = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_stream_tx.sv
// Self-checking bench for uart_stream_tx: four differently configured instances share
// one clock, reset and data bus; table vectors, directed corner cases and random bursts.
module tb_uart_stream_tx;

    logic       clk;
    logic       rst_n;
    logic [3:0] wrValid;
    logic [7:0] wrData;

    wire  [3:0] txLine;
    wire  [3:0] busyLine;
    wire  [3:0] readyLine;
    wire  [3:0] levA;
    wire  [2:0] levB;
    wire  [1:0] levC;
    wire  [3:0] levD;

    // Instance configuration as seen by the reference model.
    localparam int CPB  [4] = '{4, 4, 3, 4};
    localparam int DB   [4] = '{8, 8, 5, 8};
    localparam int PEN  [4] = '{0, 1, 0, 1};
    localparam int PODD [4] = '{0, 0, 0, 1};
    localparam int SB   [4] = '{1, 1, 2, 1};

    typedef struct {
        int         inst;
        logic [7:0] data;
        string      line;
        string      name;
    } vec_t;

    int   nChecks = 0;
    int   nFail   = 0;
    bit   expQ[$];
    vec_t vecs [10];

    uart_stream_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                     .STOP_BITS(1), .FIFO_DEPTH(8)) uA (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wrValid[0]), .wr_data_i(wrData),
        .wr_ready_o(readyLine[0]), .fifo_level_o(levA), .busy_o(busyLine[0]), .uart_tx_o(txLine[0]));

    uart_stream_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) uB (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wrValid[1]), .wr_data_i(wrData),
        .wr_ready_o(readyLine[1]), .fifo_level_o(levB), .busy_o(busyLine[1]), .uart_tx_o(txLine[1]));

    uart_stream_tx #(.CLKS_PER_BIT(3), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0),
                     .STOP_BITS(2), .FIFO_DEPTH(2)) uC (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wrValid[2]), .wr_data_i(wrData[4:0]),
        .wr_ready_o(readyLine[2]), .fifo_level_o(levC), .busy_o(busyLine[2]), .uart_tx_o(txLine[2]));

    uart_stream_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                     .STOP_BITS(1), .FIFO_DEPTH(8)) uD (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wrValid[3]), .wr_data_i(wrData),
        .wr_ready_o(readyLine[3]), .fifo_level_o(levD), .busy_o(busyLine[3]), .uart_tx_o(txLine[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] levelOf(input int inst);
        case (inst)
            0:       return {28'd0, levA};
            1:       return {29'd0, levB};
            2:       return {30'd0, levC};
            default: return {28'd0, levD};
        endcase
    endfunction

    // Reference frame: start 0, data LSB first, parity from the count of ones, stop 1s.
    function automatic void buildFrame(input int inst, input logic [7:0] d);
        int ones = 0;
        expQ.push_back(1'b0);
        for (int i = 0; i < DB[inst]; i++) begin
            expQ.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (PEN[inst] != 0) begin
            expQ.push_back(((ones % 2) != PODD[inst]) ? 1'b1 : 1'b0);
        end
        for (int s = 0; s < SB[inst]; s++) begin
            expQ.push_back(1'b1);
        end
    endfunction

    function automatic void loadLine(input string s);
        for (int i = 0; i < s.len(); i++) begin
            expQ.push_back(s.getc(i) == 8'd49);
        end
    endfunction

    task automatic checkEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offers one byte for exactly one rising edge; returns the ready seen before that edge.
    task automatic applyStimulus(input int inst, input logic [7:0] d, output bit accepted);
        @(negedge clk);
        wrValid[inst] = 1'b1;
        wrData        = d;
        accepted      = readyLine[inst];
        @(posedge clk);
        #1;
        wrValid[inst] = 1'b0;
    endtask

    // Walks expQ one cycle at a time (starting 'skip' cycles into the stream), one
    // comparison per line bit, then expects the line idle and busy low.
    task automatic checkOutput(input int inst, input int skip, input string name);
        int         cpb   = CPB[inst];
        int         total = expQ.size() * cpb;
        bit         bitOk = 1'b1;
        logic [1:0] got   = 2'b00;
        for (int t = skip; t < total; t++) begin
            if (txLine[inst] !== expQ[t / cpb] || busyLine[inst] !== 1'b1) begin
                if (bitOk) got = {busyLine[inst], txLine[inst]};
                bitOk = 1'b0;
            end
            if ((t % cpb) == cpb - 1) begin
                checkEq($sformatf("%s bit%0d busy/tx", name, t / cpb),
                        bitOk ? {30'd0, 1'b1, expQ[t / cpb]} : {30'd0, got},
                        {30'd0, 1'b1, expQ[t / cpb]});
                bitOk = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        checkEq({name, " end busy/tx"}, {30'd0, busyLine[inst], txLine[inst]}, 32'd1);
        expQ.delete();
    endtask

    initial begin
        bit   acc;
        bit   allAcc;
        bit   quiet;
        int   inst;
        int   k;
        logic [7:0] d;

        rst_n   = 1'b0;
        wrValid = '0;
        wrData  = '0;

        vecs[0] = '{0, 8'hA5, "0101001011",  "A 0xA5"};
        vecs[1] = '{0, 8'h00, "0000000001",  "A 0x00"};
        vecs[2] = '{0, 8'hFF, "0111111111",  "A 0xFF"};
        vecs[3] = '{1, 8'h07, "01110000011", "B even 0x07"};
        vecs[4] = '{1, 8'h00, "00000000001", "B even 0x00"};
        vecs[5] = '{3, 8'h07, "01110000001", "D odd 0x07"};
        vecs[6] = '{3, 8'h00, "00000000011", "D odd 0x00"};
        vecs[7] = '{2, 8'h1F, "01111111",    "C 5b2s 0x1F"};
        vecs[8] = '{2, 8'h0A, "00101011",    "C 5b2s 0x0A"};
        vecs[9] = '{0, 8'h3C, "0001111001",  "A 0x3C"};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checkEq($sformatf("reset tx%0d", i),    {31'd0, txLine[i]},    32'd1);
            checkEq($sformatf("reset busy%0d", i),  {31'd0, busyLine[i]},  32'd0);
            checkEq($sformatf("reset ready%0d", i), {31'd0, readyLine[i]}, 32'd1);
            checkEq($sformatf("reset level%0d", i), levelOf(i),            32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] table vectors");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].inst, vecs[v].data, acc);
            checkEq({vecs[v].name, " accepted"}, {31'd0, acc}, 32'd1);
            @(posedge clk);
            #1;
            loadLine(vecs[v].line);
            checkOutput(vecs[v].inst, 0, vecs[v].name);
        end

        $display("[TB] back-to-back frames");
        applyStimulus(0, 8'h11, acc);
        applyStimulus(0, 8'h22, allAcc);
        checkEq("b2b accepted", {31'd0, acc & allAcc}, 32'd1);
        buildFrame(0, 8'h11);
        buildFrame(0, 8'h22);
        checkOutput(0, 0, "b2b");

        $display("[TB] fifo full");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 8'(8'h31 + i), acc);
            checkEq($sformatf("full write%0d accepted", i), {31'd0, acc}, {31'd0, i < 5});
        end
        checkEq("full level", levelOf(1), 32'd4);
        checkEq("full ready", {31'd0, readyLine[1]}, 32'd0);
        for (int i = 0; i < 5; i++) buildFrame(1, 8'(8'h31 + i));
        checkOutput(1, 4, "full drain");

        $display("[TB] random bursts");
        for (int r = 0; r < 30; r++) begin
            inst   = int'($urandom_range(0, 3));
            k      = int'($urandom_range(1, 3));
            allAcc = 1'b1;
            for (int j = 0; j < k; j++) begin
                d = 8'($urandom);
                applyStimulus(inst, d, acc);
                allAcc &= acc;
                buildFrame(inst, d);
            end
            checkEq($sformatf("rand%0d accepted", r), {31'd0, allAcc}, 32'd1);
            if (k == 1) begin
                @(posedge clk);
                #1;
                checkOutput(inst, 0, $sformatf("rand%0d", r));
            end else begin
                checkOutput(inst, k - 2, $sformatf("rand%0d", r));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h00, acc);
        applyStimulus(0, 8'h5A, acc);
        applyStimulus(0, 8'h5A, acc);
        applyStimulus(0, 8'h5A, acc);
        repeat (4) @(posedge clk);
        #1;
        checkEq("pre-reset tx", {31'd0, txLine[0]}, 32'd0);
        checkEq("pre-reset level", levelOf(0), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("async reset tx",    {31'd0, txLine[0]},    32'd1);
        checkEq("async reset level", levelOf(0),            32'd0);
        checkEq("async reset busy",  {31'd0, busyLine[0]},  32'd0);
        checkEq("async reset ready", {31'd0, readyLine[0]}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (txLine[0] !== 1'b1 || busyLine[0] !== 1'b0 || levA !== 4'd0) quiet = 1'b0;
        end
        checkEq("quiet after reset", {31'd0, quiet}, 32'd1);

        $display("[TB] push on first edge after reset");
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n      = 1'b1;
        wrValid[0] = 1'b1;
        wrData     = 8'h3C;
        @(posedge clk);
        #1;
        wrValid[0] = 1'b0;
        checkEq("first edge push level", levelOf(0), 32'd1);
        @(posedge clk);
        #1;
        buildFrame(0, 8'h3C);
        checkOutput(0, 0, "post-reset frame");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
